// File: rtl/sdram_port_arbiter_if.sv
// Requester and controller bus bundle for sdram_port_arbiter.
// slave = arbiter side; master = clients plus controller side.
interface sdram_port_arbiter_if #(
  parameter int AW = 24
);
  logic [2:0]      p_req;
  logic [2:0]      p_we;
  logic [3*AW-1:0] p_addr;
  logic [47:0]     p_wdata;
  logic [5:0]      p_be;
  logic [2:0]      p_ack;
  logic [2:0]      p_err;
  logic [15:0]     p_rdata;
  logic            ctl_req;
  logic            ctl_we;
  logic [AW-1:0]   ctl_addr;
  logic [15:0]     ctl_wdata;
  logic [1:0]      ctl_be;
  logic            ctl_ack;
  logic [15:0]     ctl_rdata;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata, p_be,
    output p_ack, p_err, p_rdata,
    output ctl_req, ctl_we, ctl_addr, ctl_wdata, ctl_be,
    input  ctl_ack, ctl_rdata
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata, p_be,
    input  p_ack, p_err, p_rdata,
    input  ctl_req, ctl_we, ctl_addr, ctl_wdata, ctl_be,
    output ctl_ack, ctl_rdata
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Three-port SDRAM controller arbiter with watchdog abort.
// Ports: clk, reset_n, bus (p_*/ctl_*), busy. Option: SDRAM_ARB_AGING_EN.
module sdram_port_arbiter #(
  parameter int AW        = 24,
  parameter int TIMEOUT   = 255,
  parameter int AGE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sdram_port_arbiter_if.slave   bus,
  output logic                  busy
);

  if (TIMEOUT < 1 || TIMEOUT > 65535 ||
      AGE_LIMIT < 1 || AGE_LIMIT > 15) begin : g_param_err
    $error("sdram_port_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [16:0] TO = 17'(TIMEOUT);

  state_t        state_q, state_d;
  logic [2:0]    win_q, win_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [1:0]    be_q, be_d;
  logic [2:0]    ack_q, ack_d;
  logic [2:0]    err_q, err_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [15:0]   wdog_q, wdog_d;
  logic          busy_q, busy_d;

  logic [2:0]    cand, pick;
  logic          expire;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [15:0]   sel_wdata;
  logic [1:0]    sel_be;

`ifdef SDRAM_ARB_AGING_EN
  logic [2:0][3:0] age_q, age_d;
  logic [2:0]      aged;

  always_comb begin
    aged = '0;
    for (int i = 0; i < 3; i++)
      aged[i] = bus.p_req[i] && (age_q[i] >= 4'(AGE_LIMIT));
    // aged requesters outrank everyone else
    cand = (|aged) ? aged : bus.p_req;
  end
`else
  assign cand = bus.p_req;
`endif

  // lowest set bit wins
  assign pick = cand & (~cand + 3'd1);

  // cleared in ISSUE, so WAIT edge k sees k-1; +2 lands the
  // abort exactly TIMEOUT cycles after ctl_req rose
  assign expire = ({1'b0, wdog_q} + 17'd2) >= TO;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    unique case (1'b1)
      pick[0]: begin
        sel_we    = bus.p_we[0];
        sel_addr  = bus.p_addr[0 +: AW];
        sel_wdata = bus.p_wdata[0 +: 16];
        sel_be    = bus.p_be[0 +: 2];
      end
      pick[1]: begin
        sel_we    = bus.p_we[1];
        sel_addr  = bus.p_addr[AW +: AW];
        sel_wdata = bus.p_wdata[16 +: 16];
        sel_be    = bus.p_be[2 +: 2];
      end
      pick[2]: begin
        sel_we    = bus.p_we[2];
        sel_addr  = bus.p_addr[2*AW +: AW];
        sel_wdata = bus.p_wdata[32 +: 16];
        sel_be    = bus.p_be[4 +: 2];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    wdog_d  = wdog_q;
`ifdef SDRAM_ARB_AGING_EN
    age_d   = age_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.p_req) begin
          win_d   = pick;
          req_d   = 1'b1;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          be_d    = sel_be;
          state_d = ISSUE;
`ifdef SDRAM_ARB_AGING_EN
          for (int i = 0; i < 3; i++) begin
            if (pick[i])
              age_d[i] = '0;
            else if (bus.p_req[i] && age_q[i] != 4'hF)
              age_d[i] = age_q[i] + 4'd1;
          end
`endif
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.ctl_ack) begin
          req_d   = 1'b0;
          ack_d   = win_q;
          rdata_d = bus.ctl_rdata;
          state_d = IDLE;
        end else if (expire) begin
          req_d   = 1'b0;
          ack_d   = win_q;
          err_d   = win_q;
          rdata_d = 16'hFFFF;
          state_d = IDLE;
        end else begin
          wdog_d  = wdog_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ISSUE) || (state_d == WAIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 2'b00;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      wdog_q  <= '0;
      busy_q  <= 1'b0;
`ifdef SDRAM_ARB_AGING_EN
      age_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      wdog_q  <= wdog_d;
      busy_q  <= busy_d;
`ifdef SDRAM_ARB_AGING_EN
      age_q   <= age_d;
`endif
    end
  end

  assign bus.p_ack     = ack_q;
  assign bus.p_err     = err_q;
  assign bus.p_rdata   = rdata_q;
  assign bus.ctl_req   = req_q;
  assign bus.ctl_we    = we_q;
  assign bus.ctl_addr  = addr_q;
  assign bus.ctl_wdata = wdata_q;
  assign bus.ctl_be    = be_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter.
// Plays the three clients and the SDRAM controller.
module tb_sdram_port_arbiter;

  localparam int AW = 24;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  int   errs = 0;
  int   checks = 0;

  localparam logic [23:0] A0 = 24'h000100;
  localparam logic [23:0] A1 = 24'h001234;
  localparam logic [23:0] A2 = 24'h00ABCD;

  sdram_port_arbiter_if #(.AW(AW)) bus ();

  sdram_port_arbiter #(
    .AW(AW), .TIMEOUT(255), .AGE_LIMIT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns cycles until ctl_req seen high
  task automatic wait_grant(input string tag, output int n);
    n = 0;
    while (!bus.ctl_req && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.ctl_req), 32'd1);
  endtask

  // call in ISSUE cycle; ack arrives dly cycles later
  task automatic serve(input string tag, input int dly,
                       input logic [15:0] rd,
                       input logic [2:0] exp_ack);
    repeat (dly) tick();
    bus.ctl_ack   = 1'b1;
    bus.ctl_rdata = rd;
    tick();
    bus.ctl_ack   = 1'b0;
    check({tag, "_ack"}, 32'(bus.p_ack), 32'(exp_ack));
    check({tag, "_rd"}, 32'(bus.p_rdata), 32'(rd));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit stable;
    bus.p_req     = '0;
    bus.p_we      = '0;
    bus.p_addr    = {A2, A1, A0};
    bus.p_wdata   = '0;
    bus.p_be      = '0;
    bus.ctl_ack   = 1'b0;
    bus.ctl_rdata = '0;

    #12;
    check("rst_req", 32'(bus.ctl_req), 32'd0);
    check("rst_ack", 32'(bus.p_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", 32'(bus.p_rdata), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // single read, port 1
    bus.p_req = 3'b010;
    wait_grant("t1_grant", n);
    check("t1_latency", 32'(n), 32'd1);
    check("t1_addr", 32'(bus.ctl_addr), 32'(A1));
    check("t1_we", 32'(bus.ctl_we), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    serve("t1", 4, 16'hBEEF, 3'b010);
    check("t1_req_low", 32'(bus.ctl_req), 32'd0);
    bus.p_req = '0;
    tick();
    check("t1_ack_pulse", 32'(bus.p_ack), 32'd0);

    // write, port 2
    bus.p_we[2]         = 1'b1;
    bus.p_wdata[32 +: 16] = 16'hA55A;
    bus.p_be[4 +: 2]    = 2'b01;
    bus.p_req           = 3'b100;
    wait_grant("t2_grant", n);
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.ctl_we !== 1'b1 || bus.ctl_wdata !== 16'hA55A ||
          bus.ctl_be !== 2'b01 || bus.ctl_addr !== A2 ||
          bus.ctl_req !== 1'b1)
        stable = 1'b0;
      tick();
    end
    check("t2_stable", 32'(stable), 32'd1);
    serve("t2", 0, 16'h0042, 3'b100);
    bus.p_req = '0;
    bus.p_we  = '0;
    tick();

    // simultaneous requests: 0 then 1 then 2
    bus.p_req = 3'b111;
    wait_grant("t3_g0", n);
    check("t3_addr0", 32'(bus.ctl_addr), 32'(A0));
    serve("t3_0", 2, 16'h1000, 3'b001);
    bus.p_req[0] = 1'b0;
    wait_grant("t3_g1", n);
    check("t3_addr1", 32'(bus.ctl_addr), 32'(A1));
    serve("t3_1", 2, 16'h1001, 3'b010);
    bus.p_req[1] = 1'b0;
    wait_grant("t3_g2", n);
    check("t3_addr2", 32'(bus.ctl_addr), 32'(A2));
    serve("t3_2", 2, 16'h1002, 3'b100);
    bus.p_req = '0;
    tick();

`ifdef SDRAM_ARB_AGING_EN
    // port 0 hogs; port 2 promoted on 5th decision
    bus.p_req = 3'b101;
    for (int k = 0; k < 4; k++) begin
      wait_grant("t4_g", n);
      check("t4_win0", 32'(bus.ctl_addr), 32'(A0));
      serve("t4", 1, 16'(k), 3'b001);
    end
    wait_grant("t4_g5", n);
    check("t4_win2", 32'(bus.ctl_addr), 32'(A2));
    serve("t4_5", 1, 16'h2222, 3'b100);
    wait_grant("t4_g6", n);
    check("t4_after", 32'(bus.ctl_addr), 32'(A0));
    serve("t4_6", 1, 16'h3333, 3'b001);
`else
    // port 0 hogs; port 2 starves under fixed priority
    bus.p_req = 3'b101;
    for (int k = 0; k < 5; k++) begin
      wait_grant("t3s_g", n);
      check("t3s_win0", 32'(bus.ctl_addr), 32'(A0));
      serve("t3s", 1, 16'(k), 3'b001);
    end
    bus.p_req[0] = 1'b0;
    wait_grant("t3s_g2", n);
    check("t3s_win2", 32'(bus.ctl_addr), 32'(A2));
    serve("t3s_2", 1, 16'h2222, 3'b100);
`endif
    bus.p_req = '0;
    tick();

    // watchdog abort, port 0
    bus.p_req = 3'b001;
    wait_grant("t5_grant", n);
    n = 0;
    while (bus.ctl_req && n < 400) begin
      tick();
      n++;
    end
    check("t5_drop_cyc", 32'(n), 32'd255);
    check("t5_ack", 32'(bus.p_ack), 32'd1);
    check("t5_err", 32'(bus.p_err), 32'd1);
    check("t5_rdata", 32'(bus.p_rdata), 32'hFFFF);
    bus.p_req = '0;
    tick();
    check("t5_err_pulse", 32'(bus.p_err), 32'd0);

    // stray ctl_ack in IDLE is ignored
    bus.ctl_ack = 1'b1;
    tick();
    bus.ctl_ack = 1'b0;
    tick();
    check("idle_ack_ign", 32'(bus.p_ack), 32'd0);

    // ctl_ack during ISSUE is ignored; then normal service
    bus.p_req = 3'b010;
    wait_grant("t5b_grant", n);
    bus.ctl_ack = 1'b1;
    tick();
    bus.ctl_ack = 1'b0;
    check("issue_ack_ign", 32'(bus.p_ack), 32'd0);
    check("issue_req_hold", 32'(bus.ctl_req), 32'd1);
    serve("t5b", 1, 16'h5678, 3'b010);
    check("t5b_err", 32'(bus.p_err), 32'd0);
    bus.p_req = '0;
    tick();

    // async reset during WAIT
    bus.p_req = 3'b010;
    wait_grant("t6_grant", n);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_req", 32'(bus.ctl_req), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_addr", 32'(bus.ctl_addr), 32'd0);
    check("t6_rdata", 32'(bus.p_rdata), 32'd0);
    tick();
    reset_n = 1'b1;
    wait_grant("t6_regrant", n);
    check("t6_addr1", 32'(bus.ctl_addr), 32'(A1));
    serve("t6", 1, 16'h9ABC, 3'b010);
    bus.p_req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
